irrigation_zone_sequencer: RTL and testbench

Controller that runs a watering cycle over up to ZONES valve zones. It opens one zone at a time and drives an internal per-zone countdown from an external 1 Hz tick. Zones are taken in ascending index order, with a one-cycle all-valves-off gap between zones. It sits above the timer counters and is driven by the user-panel FSM; its valve outputs go to the actuator drivers.

---
 rtl/irrigation_zone_sequencer.sv | 119 +++++++++++
 tb/tb_irrigation_zone_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_zone_sequencer.sv
// irrigation_zone_sequencer: waters the masked valve zones one at a time in ascending order,
// counting each zone down on an external tick with a one-cycle all-off gap between zones.
module irrigation_zone_sequencer #(
    parameter int ZONES  = 4,
    parameter int ZONE_W = 2,
    parameter int DUR_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic              tick,
    input  logic [ZONES-1:0]  zone_mask,
    input  logic [DUR_W-1:0]  duration,
    output logic [ZONES-1:0]  valve,
    output logic [ZONE_W-1:0] zone,
    output logic [DUR_W-1:0]  remaining,
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    typedef enum logic [2:0] {IDLE, RUN, PAUSE, GAP, DONE} state_t;
    state_t state, state_n;
    logic [ZONES-1:0] mask_q, higher, valve_n;
    logic [DUR_W-1:0] dur_q, remaining_n;
    logic [ZONE_W-1:0] zone_n;
    logic busy_n, done_n, aborted_n;

    function automatic logic [ZONE_W-1:0] lowest(input logic [ZONES-1:0] m);
        logic [ZONE_W-1:0] idx;
        idx = '0;
        for (int i = ZONES - 1; i >= 0; i--) if (m[i]) idx = ZONE_W'(i);
        return idx;
    endfunction

    // Latched zones strictly above the current one; a cycle never wraps back.
    assign higher = mask_q & ~((ZONES'(2) << zone) - ZONES'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mask_q    <= '0;
            dur_q     <= '0;
            zone      <= '0;
            remaining <= '0;
            valve     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                mask_q <= zone_mask;
                dur_q  <= duration;
            end
            zone      <= zone_n;
            remaining <= remaining_n;
            valve     <= valve_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
        end
    end

    always_comb begin
        state_n     = state;
        zone_n      = zone;
        remaining_n = remaining;
        case (state)
            IDLE:
                if (start) begin
                    if (|zone_mask && |duration) begin
                        state_n     = RUN;
                        zone_n      = lowest(zone_mask);
                        remaining_n = duration;
                    end else begin
                        state_n = DONE;
                    end
                end
            RUN:
                if (abort) begin
                    state_n     = IDLE;
                    remaining_n = '0;
                end else if (pause) begin
                    state_n = PAUSE;
                end else if (tick) begin
                    remaining_n = remaining - DUR_W'(1);
                    state_n     = (remaining == DUR_W'(1)) ? GAP : RUN;
                end
            PAUSE:
                if (abort) begin
                    state_n     = IDLE;
                    remaining_n = '0;
                end else if (!pause) begin
                    state_n = RUN;
                end
            GAP:
                if (abort) begin
                    state_n = IDLE;
                end else if (|higher) begin
                    state_n     = RUN;
                    zone_n      = lowest(higher);
                    remaining_n = dur_q;
                end else begin
                    state_n = DONE;
                end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so the valve opens the cycle after start.
    always_comb begin
        valve_n   = (state_n == RUN) ? ZONES'(1) << zone_n : '0;
        busy_n    = state_n != IDLE;
        done_n    = state_n == DONE;
        aborted_n = abort && (state == RUN || state == PAUSE || state == GAP);
    end
endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// tb_irrigation_zone_sequencer: directed scenarios plus randomized traffic against a
// queue-based model of the watering cycle.
module tb_irrigation_zone_sequencer;
    logic clock = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, pause = 1'b0, tick = 1'b0;
    logic [3:0] zone_mask = '0;
    logic [7:0] duration = '0;
    logic [3:0] valve;
    logic [1:0] zone;
    logic [7:0] remaining;
    logic busy, done, aborted;
    int checks = 0, failures = 0;

    // model: ph 0 idle, 1 watering, 2 paused, 3 gap, 4 done; q holds zones still to water
    int ph = 0, cur = 0, left = 0, m_dur = 0;
    int q[$];
    logic [3:0] e_valve = '0;
    logic [1:0] e_zone = '0;
    logic [7:0] e_rem = '0;
    logic e_busy = 1'b0, e_done = 1'b0, e_ab = 1'b0;

    irrigation_zone_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .pause(pause), .tick(tick),
        .zone_mask(zone_mask), .duration(duration), .valve(valve), .zone(zone),
        .remaining(remaining), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        e_ab = 1'b0;
        if (reset) begin
            ph = 0; cur = 0; left = 0; m_dur = 0; q.delete();
        end else begin
            case (ph)
                0: if (start) begin
                    if (zone_mask != 0 && duration != 0) begin
                        q.delete();
                        for (int i = 0; i < 4; i++) if (zone_mask[i]) q.push_back(i);
                        cur = q.pop_front(); left = duration; m_dur = duration; ph = 1;
                    end else ph = 4;
                end
                1, 2: if (abort) begin
                    ph = 0; left = 0; e_ab = 1'b1;
                end else if (pause) ph = 2;
                else if (ph == 2) ph = 1;
                else if (tick) begin
                    left--;
                    if (left == 0) ph = 3;
                end
                3: if (abort) begin
                    ph = 0; e_ab = 1'b1;
                end else if (q.size() > 0) begin
                    cur = q.pop_front(); left = m_dur; ph = 1;
                end else ph = 4;
                default: ph = 0;
            endcase
        end
        e_valve = (ph == 1) ? 4'b0001 << cur : 4'b0000;
        e_zone = cur[1:0];
        e_rem = left[7:0];
        e_busy = ph != 0;
        e_done = ph == 4;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        checks++;
        if ({valve, zone, remaining, busy, done, aborted} !== 17'd0) begin
            failures++;
            $display("FAIL reset: valve=%b zone=%0d rem=%0d busy=%b done=%b ab=%b, want all 0",
                     valve, zone, remaining, busy, done, aborted);
        end
    endtask

    task automatic test_basic();
        int gap_zero = 0, seen_z2 = 0;
        zone_mask = 4'b0101; duration = 8'd3; start = 1'b1; step(); start = 1'b0;
        checks++;
        if (valve !== 4'b0001 || remaining !== 8'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_open: valve=%b rem=%0d busy=%b, want 0001 3 1", valve, remaining, busy);
        end
        for (int c = 0; c < 200 && done !== 1'b1; c++) begin
            tick = (c % 4 == 3); step();
            if (valve == 4'b0100) seen_z2 = 1;
            else if (valve == 4'b0000 && !seen_z2 && done !== 1'b1) gap_zero++;
        end
        tick = 1'b0;
        checks++;
        if (done !== 1'b1 || seen_z2 != 1 || gap_zero != 1) begin
            failures++;
            $display("FAIL basic_seq: done=%b zone2_seen=%0d gap_cycles=%0d, want 1 1 1", done, seen_z2, gap_zero);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_single();
        int n = 0;
        zone_mask = 4'b1000; duration = 8'd1; start = 1'b1; step(); start = 1'b0;
        checks++;
        if (valve !== 4'b1000 || remaining !== 8'd1) begin
            failures++;
            $display("FAIL single_open: valve=%b rem=%0d, want 1000 1", valve, remaining);
        end
        tick = 1'b1; step(); tick = 1'b0;
        checks++;
        if (valve !== 4'b0000 || remaining !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_gap: valve=%b rem=%0d busy=%b, want 0000 0 1", valve, remaining, busy);
        end
        step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL single_done: done=%b, want 1", done);
        end
        step();
        duration = 8'd255; start = 1'b1; step(); start = 1'b0;
        tick = 1'b1;
        while (remaining !== 8'd0 && n < 300) begin
            step(); n++;
        end
        tick = 1'b0;
        checks++;
        if (n != 255) begin
            failures++;
            $display("FAIL single_255: ticks_to_zero=%0d, want 255", n);
        end
        step(); step();
    endtask

    task automatic test_degenerate();
        logic [3:0] ms[2] = '{4'b0000, 4'b0011};
        logic [7:0] ds[2] = '{8'd5, 8'd0};
        for (int k = 0; k < 2; k++) begin
            zone_mask = ms[k]; duration = ds[k]; start = 1'b1; step(); start = 1'b0;
            checks++;
            if (busy !== 1'b1 || done !== 1'b1 || valve !== 4'b0000) begin
                failures++;
                $display("FAIL degen%0d_done: busy=%b done=%b valve=%b, want 1 1 0000", k, busy, done, valve);
            end
            step();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || valve !== 4'b0000) begin
                failures++;
                $display("FAIL degen%0d_idle: busy=%b done=%b valve=%b, want 0 0 0000", k, busy, done, valve);
            end
        end
    endtask

    task automatic test_pause();
        int bad = 0, n = 0;
        zone_mask = 4'b0001; duration = 8'd5; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        pause = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick = (c == 2 || c == 5 || c == 8); step();
            if (valve !== 4'b0000 || remaining !== 8'd3 || busy !== 1'b1) bad++;
        end
        pause = 1'b0; tick = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pause_hold: %0d cycles off, want valve 0000 rem 3", bad);
        end
        step();
        checks++;
        if (valve !== 4'b0001 || remaining !== 8'd3) begin
            failures++;
            $display("FAIL pause_resume: valve=%b rem=%0d, want 0001 3", valve, remaining);
        end
        tick = 1'b1;
        while (remaining !== 8'd0 && n < 10) begin
            step(); n++;
        end
        tick = 1'b0; step();
        checks++;
        if (n != 3 || done !== 1'b1) begin
            failures++;
            $display("FAIL pause_finish: ticks=%0d done=%b, want 3 1", n, done);
        end
        step();
    endtask

    task automatic test_abort_busy();
        zone_mask = 4'b0110; duration = 8'd4; start = 1'b1; step(); start = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        zone_mask = 4'b1111; duration = 8'd9; start = 1'b1; step(); start = 1'b0;
        checks++;
        if (zone !== 2'd1 || remaining !== 8'd3 || valve !== 4'b0010) begin
            failures++;
            $display("FAIL start_busy: zone=%0d rem=%0d valve=%b, want 1 3 0010", zone, remaining, valve);
        end
        tick = 1'b1; repeat (3) step(); tick = 1'b0; step();
        checks++;
        if (zone !== 2'd2 || remaining !== 8'd4 || valve !== 4'b0100) begin
            failures++;
            $display("FAIL second_zone: zone=%0d rem=%0d valve=%b, want 2 4 0100", zone, remaining, valve);
        end
        abort = 1'b1; step(); abort = 1'b0;
        checks++;
        if (aborted !== 1'b1 || valve !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || remaining !== 8'd0) begin
            failures++;
            $display("FAIL abort: ab=%b valve=%b busy=%b done=%b rem=%0d, want 1 0000 0 0 0",
                     aborted, valve, busy, done, remaining);
        end
        step();
        checks++;
        if (aborted !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_after: ab=%b done=%b busy=%b, want 0 0 0", aborted, done, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int bad = 0;
        zone_mask = 4'b0010; duration = 8'd7; start = 1'b1; step(); start = 1'b0;
        checks++;
        if (valve !== 4'b0010 || remaining !== 8'd7) begin
            failures++;
            $display("FAIL rst_pre: valve=%b rem=%0d, want 0010 7", valve, remaining);
        end
        reset = 1'b1; step(); reset = 1'b0;
        checks++;
        if ({valve, zone, remaining, busy, done, aborted} !== 17'd0) begin
            failures++;
            $display("FAIL rst_mid: valve=%b zone=%0d rem=%0d busy=%b, want all 0", valve, zone, remaining, busy);
        end
        zone_mask = 4'b0100; duration = 8'd2; start = 1'b1; step(); start = 1'b0;
        tick = 1'b1;
        for (int c = 0; c < 20 && done !== 1'b1; c++) begin
            if (valve !== 4'b0000 && valve !== 4'b0100) bad++;
            step();
        end
        tick = 1'b0;
        checks++;
        if (bad != 0 || done !== 1'b1 || zone !== 2'd2) begin
            failures++;
            $display("FAIL rst_rerun: bad_valve=%0d done=%b zone=%0d, want 0 1 2", bad, done, zone);
        end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom % 300) == 0;
            start = ($urandom % 6) == 0;
            abort = ($urandom % 50) == 0;
            if (($urandom % 15) == 0) pause = ~pause;
            tick = ($urandom % 3) == 0;
            zone_mask = 4'($urandom);
            duration = 8'($urandom % 5);
            step();
            checks++;
            if ({valve, zone, remaining, busy, done, aborted} !== {e_valve, e_zone, e_rem, e_busy, e_done, e_ab}) begin
                failures++;
                $display("FAIL random c%0d: got v=%b z=%0d r=%0d b=%b d=%b a=%b want v=%b z=%0d r=%0d b=%b d=%b a=%b",
                         c, valve, zone, remaining, busy, done, aborted,
                         e_valve, e_zone, e_rem, e_busy, e_done, e_ab);
            end
        end
        {reset, start, abort, pause, tick} = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_degenerate();
        test_pause();
        test_abort_busy();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
